// File: rtl/uart_seg_pkg.sv
// Shared types and constants for the UART-driven multiplexed 7-segment display.
// Segment bit order: {g,f,a,b,e,d,c} (bit6..bit0). Optional feature macro: UART_PARITY_EN.
package uart_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h09;
    localparam logic [6:0] SEG_2     = 7'h5E;
    localparam logic [6:0] SEG_3     = 7'h5B;
    localparam logic [6:0] SEG_4     = 7'h69;
    localparam logic [6:0] SEG_5     = 7'h73;
    localparam logic [6:0] SEG_6     = 7'h77;
    localparam logic [6:0] SEG_7     = 7'h19;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h7D;
    localparam logic [6:0] SEG_B     = 7'h67;
    localparam logic [6:0] SEG_C     = 7'h36;
    localparam logic [6:0] SEG_D     = 7'h4F;
    localparam logic [6:0] SEG_E     = 7'h76;
    localparam logic [6:0] SEG_F     = 7'h74;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] val;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, val: 4'h0};

    // Pattern for one buffer entry; blank entries light nothing.
    function automatic logic [6:0] seg_pattern(input digit_t d);
        logic [6:0] p;
        case (d.val)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_A;
            4'hB: p = SEG_B;
            4'hC: p = SEG_C;
            4'hD: p = SEG_D;
            4'hE: p = SEG_E;
            default: p = SEG_F;
        endcase
        return d.blank ? SEG_BLANK : p;
    endfunction

    // Returns {is_hex, nibble} for an ASCII character.
    function automatic logic [4:0] ascii_hex(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, 4'(c[3:0] + 4'd9)};
        else
            return 5'b0_0000;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling FSM, byte/frame-error pulses.
// 8N1 by default; UART_PARITY_EN adds an even-parity bit and the parity_err pulse.
module uart_rx_core
    import uart_seg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_ok;
`ifdef UART_PARITY_EN
    logic             par_bad;
    assign byte_ok = !par_bad;
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM; counter restarts at 1 on each sample so it stays within CLKS_PER_BIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= ONE;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= ONE;
                        bit_idx <= '0;
`ifdef UART_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= ONE;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (cnt == FULL) begin
                        cnt   <= ONE;
                        state <= RX_STOP;
                        if (rx_s != ^shreg) begin
                            par_bad    <= 1'b1;
                            parity_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= ONE;
                        if (rx_s) begin
                            state <= RX_IDLE;
                            if (byte_ok) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shreg;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_seg_scanner.sv
// UART-fed hex digit buffer scanned onto a shared 7-segment bus with one-hot digit enables.
// Optional even-parity reception when UART_PARITY_EN is defined (adds parity_err port).
module uart_seg_scanner
    import uart_seg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 234,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 27000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  frame_err
`ifdef UART_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL   = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    digit_t            digits [NUM_DIGITS];
    logic [4:0]        hex;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  next_idx;

    assign hex      = ascii_hex(byte_data);
    assign next_idx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

    // Hex characters shift in at position 0; CR blanks the whole buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= DIGIT_BLANK;
        end else if (byte_valid) begin
            if (byte_data == ASCII_CR) begin
                for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= DIGIT_BLANK;
            end else if (hex[4]) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) digits[i] <= digits[i-1];
                digits[0] <= '{blank: 1'b0, val: hex[3:0]};
            end
        end
    end

    // Scan step: select the next digit and latch its pattern together with the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            dig_sel  <= NUM_DIGITS'(1) ^ DIG_POL;
            seg      <= SEG_BLANK ^ SEG_POL;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= next_idx;
            dig_sel  <= (NUM_DIGITS'(1) << next_idx) ^ DIG_POL;
            seg      <= seg_pattern(digits[next_idx]) ^ SEG_POL;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_seg_scanner.sv
// Scoreboard bench for uart_seg_scanner: bytes expected on byte_valid are queued as they are sent.
// Covers the UART_PARITY_EN build when that macro is defined.
module tb_uart_seg_scanner;

    localparam int unsigned CPB = 234;
    localparam int unsigned ND  = 4;
    localparam int unsigned SD  = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic [6:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_err;
`ifdef UART_PARITY_EN
    logic          parity_err;
    bit            par_flip = 1'b0;
    int            pcount   = 0;
`endif

    int total  = 0;
    int bad    = 0;
    int vcount = 0;
    int fcount = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_seg_scanner #(
        .CLKS_PER_BIT   (CPB),
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (rx),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Scoreboard: every byte_valid must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (rst_n && byte_valid) begin
            logic [7:0] e;
            vcount++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte got=%h required=none", byte_data);
            end else begin
                e = exp_q.pop_front();
                if (byte_data !== e) begin
                    bad++;
                    $display("FAIL byte_data got=%h required=%h", byte_data, e);
                end
            end
        end
        if (rst_n && frame_err) fcount++;
`ifdef UART_PARITY_EN
        if (rst_n && parity_err) pcount++;
`endif
    end

    task automatic send_byte(input logic [7:0] d, input logic stop, input int idle);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_PARITY_EN
        rx = par_flip ? ~(^d) : ^d;
        repeat (CPB) @(posedge clk);
`endif
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (idle) @(posedge clk);
    endtask

    task automatic get_slot(input logic [ND-1:0] sel, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 'x;
        for (int i = 0; i < int'(2 * ND * SD + 4); i++) begin
            @(negedge clk);
            if (dig_sel === sel) begin
                s  = seg;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (seg !== 7'h00)      begin bad++; $display("FAIL rst_seg got=%h required=00", seg); end
        total++; if (dig_sel !== 4'b0001) begin bad++; $display("FAIL rst_dig_sel got=%b required=0001", dig_sel); end
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL rst_byte_valid got=%b required=0", byte_valid); end
        @(posedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        rx = 1'b0;
        repeat (600) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (seg !== 7'h00)      begin bad++; $display("FAIL midrst_seg got=%h required=00", seg); end
        total++; if (dig_sel !== 4'b0001) begin bad++; $display("FAIL midrst_dig_sel got=%b required=0001", dig_sel); end
        total++; if (byte_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL midrst_pulses got=%b%b required=00", byte_valid, frame_err);
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        total++; if (vcount != 0 || fcount != 0) begin
            bad++; $display("FAIL midrst_spurious got=%0d/%0d required=0/0", vcount, fcount);
        end
    endtask

    task automatic test_hex();
        logic [7:0] str [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h7A};
        logic [6:0] exp_seg [4] = '{7'h69, 7'h5B, 7'h5E, 7'h09};
        logic [6:0] s;
        bit ok;
        int v0 = vcount;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(str[i]);
            send_byte(str[i], 1'b1, 2 * CPB);
        end
        total++; if (vcount - v0 != 5) begin bad++; $display("FAIL hex_count got=%0d required=5", vcount - v0); end
        for (int k = 0; k < 4; k++) begin
            get_slot(ND'(1) << k, s, ok);
            total++; if (!ok || s !== exp_seg[k]) begin
                bad++; $display("FAIL hex_slot%0d got=%h required=%h", k, s, exp_seg[k]);
            end
        end
    endtask

    task automatic test_cr();
        logic [6:0] s;
        bit ok;
        int lit = 0;
        exp_q.push_back(8'h31); send_byte(8'h31, 1'b1, 2 * CPB);
        exp_q.push_back(8'h32); send_byte(8'h32, 1'b1, 2 * CPB);
        get_slot(4'b0001, s, ok);
        total++; if (!ok || s !== 7'h5E) begin bad++; $display("FAIL cr_pre got=%h required=5e", s); end
        exp_q.push_back(8'h0D); send_byte(8'h0D, 1'b1, 2 * CPB);
        for (int i = 0; i < int'(4 * SD); i++) begin
            @(negedge clk);
            if (seg !== 7'h00) lit++;
        end
        total++; if (lit != 0) begin bad++; $display("FAIL cr_blank got=%0d lit cycles required=0", lit); end
    endtask

    task automatic test_frame_err();
        logic [6:0] s;
        bit ok;
        int v0 = vcount;
        int f0 = fcount;
        send_byte(8'h35, 1'b0, 2 * CPB);
        total++; if (fcount - f0 != 1 || vcount != v0) begin
            bad++; $display("FAIL ferr_pulse got=fe%0d bv%0d required=fe1 bv0", fcount - f0, vcount - v0);
        end
        get_slot(4'b0001, s, ok);
        total++; if (!ok || s !== 7'h00) begin bad++; $display("FAIL ferr_buffer got=%h required=00", s); end
        exp_q.push_back(8'h35); send_byte(8'h35, 1'b1, 2 * CPB);
        get_slot(4'b0001, s, ok);
        total++; if (!ok || s !== 7'h73) begin bad++; $display("FAIL ferr_recover got=%h required=73", s); end
        rx = 1'b0;
        repeat (15 * CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        total++; if (fcount - f0 != 2) begin bad++; $display("FAIL break_once got=%0d required=2", fcount - f0); end
    endtask

    task automatic test_glitch();
        logic [6:0] s;
        bit ok;
        int v0 = vcount;
        int f0 = fcount;
        rx = 1'b0;
        repeat (50) @(posedge clk);
        rx = 1'b1;
        repeat (80) @(posedge clk);
        total++; if (vcount != v0 || fcount != f0) begin
            bad++; $display("FAIL glitch_pulses got=%0d/%0d required=0/0", vcount - v0, fcount - f0);
        end
        exp_q.push_back(8'h41); send_byte(8'h41, 1'b1, 2 * CPB);
        get_slot(4'b0001, s, ok);
        total++; if (!ok || s !== 7'h7D) begin bad++; $display("FAIL glitch_next got=%h required=7d", s); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg [4] = '{7'h67, 7'h7D, 7'h7D, 7'h73};
        logic [6:0] s;
        bit ok;
        exp_q.push_back(8'h61); send_byte(8'h61, 1'b1, 1);
        exp_q.push_back(8'h62); send_byte(8'h62, 1'b1, 2 * CPB);
        for (int k = 0; k < 4; k++) begin
            get_slot(ND'(1) << k, s, ok);
            total++; if (!ok || s !== exp_seg[k]) begin
                bad++; $display("FAIL b2b_slot%0d got=%h required=%h", k, s, exp_seg[k]);
            end
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [6:0] s;
        bit ok;
        int v0 = vcount;
        int p0 = pcount;
        par_flip = 1'b1;
        send_byte(8'h37, 1'b1, 2 * CPB);
        par_flip = 1'b0;
        total++; if (pcount - p0 != 1 || vcount != v0) begin
            bad++; $display("FAIL parity_bad got=pe%0d bv%0d required=pe1 bv0", pcount - p0, vcount - v0);
        end
        exp_q.push_back(8'h37); send_byte(8'h37, 1'b1, 2 * CPB);
        get_slot(4'b0001, s, ok);
        total++; if (!ok || s !== 7'h19 || pcount - p0 != 1) begin
            bad++; $display("FAIL parity_good got=%h pe%0d required=19 pe1", s, pcount - p0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hex();
        test_cr();
        test_frame_err();
        test_glitch();
        test_back_to_back();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        repeat (10) @(posedge clk);
        total++; if (exp_q.size() != 0) begin
            bad++; $display("FAIL missing_bytes got=%0d outstanding required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
